// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : arm_mem_pkg
//  Purpose  : Shared SRAM geometry, controller state encoding, index helper.
//  Revision : 1.0
// ============================================================================
package arm_mem_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int IDX_W   = SRAM_AW - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  // Word index of a byte address relative to the SRAM base; wraps modulo 2^32.
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr,
                                                input logic [31:0] base);
    return IDX_W'((addr - base) >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sram_phase_cnt
//  Purpose  : Wait-state counter for one half-word phase, terminal at WAIT_CYC.
//  Revision : 1.0
// ============================================================================
module sram_phase_cnt #(
  parameter int WAIT_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam logic [3:0] TERM = 4'(WAIT_CYC);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TERM);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Purpose  : MEM-stage 32-bit access sequenced as two half-word SRAM phases.
//  Revision : 1.0
// ============================================================================
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int          WAIT_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEn,
  input  logic               rdEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  state_e             state_q;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        data_q;
  logic [31:0]        rdata_q;

  logic               w_req;
  logic               w_in_phase;
  logic               w_term;
  logic               w_dq_oe;
  logic [SRAM_DW-1:0] w_dq_out;

  assign w_req      = rdEn | wrEn;
  assign w_in_phase = (state_q == LOW) || (state_q == HIGH);

  sram_phase_cnt #(
    .WAIT_CYC (WAIT_CYC)
  ) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (~w_in_phase | w_term),
    .inc_i  (w_in_phase),
    .term_o (w_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_req) begin
            wr_q    <= wrEn;
            idx_q   <= word_idx(address, ADDR_BASE);
            data_q  <= writeData;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (w_term) begin
            if (!wr_q) rdata_q[15:0] <= SRAM_DQ;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (w_term) begin
            if (!wr_q) rdata_q[31:16] <= SRAM_DQ;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write strobe is released on the last phase cycle so data stays valid past WE_N rising.
  assign w_dq_oe   = w_in_phase & wr_q;
  assign w_dq_out  = (state_q == HIGH) ? data_q[31:16] : data_q[15:0];
  assign SRAM_DQ   = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};
  assign SRAM_WE_N = ~(w_dq_oe & ~w_term);
  assign SRAM_ADDR = {idx_q, (state_q == HIGH)};

  assign ready    = ((state_q == IDLE) & ~w_req) | (state_q == DONE);
  assign readData = rdata_q;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_ctrl
//  Purpose  : Scoreboard bench for sram_ctrl with a behavioural 16-bit SRAM.
//  Revision : 1.0
// ============================================================================
module tb_sram_ctrl;
  import arm_mem_pkg::*;

  localparam int          W    = 2;
  localparam int          LAT  = 2 * W + 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic               clk = 1'b0;
  logic               rst;
  logic               wrEn, rdEn;
  logic [31:0]        address, writeData;
  logic [31:0]        readData;
  logic               ready;
  logic [SRAM_AW-1:0] SRAM_ADDR;
  wire  [SRAM_DW-1:0] SRAM_DQ;
  logic               SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_BASE(BASE), .WAIT_CYC(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wrEn      (wrEn),
    .rdEn      (rdEn),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  // Behavioural SRAM: output valid once the address has been stable (read mode) for more than W cycles.
  logic [SRAM_DW-1:0] mem [0:(1<<SRAM_AW)-1];
  logic [SRAM_AW-1:0] m_addr_q = '0;
  logic               m_we_q   = 1'b1;
  int                 m_age_q  = 0;
  int                 m_age;
  logic               m_drv;

  always_comb begin
    m_age = 0;
    if (SRAM_WE_N) m_age = (SRAM_ADDR == m_addr_q && m_we_q) ? m_age_q + 1 : 1;
  end
  assign m_drv   = (m_age > W);
  assign SRAM_DQ = m_drv ? mem[SRAM_ADDR] : {SRAM_DW{1'bz}};

  always @(posedge clk) begin
    m_addr_q <= SRAM_ADDR;
    m_we_q   <= SRAM_WE_N;
    m_age_q  <= (m_age > 100) ? 100 : m_age;
    if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
  end

  typedef struct {
    logic        is_rd;
    logic [31:0] exp_rd;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] shadow [int];
  logic [31:0] exp_last_rd = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sh(input int k);
    return shadow.exists(k) ? shadow[k] : 16'h0000;
  endfunction

  function automatic int hw_key(input logic [31:0] a, input bit hi);
    logic [31:0] off;
    off = a - BASE;
    return int'({off[18:2], hi});
  endfunction

  task automatic set_inputs(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    wrEn = wr; rdEn = rd; address = a; writeData = d;
  endtask

  task automatic push_expect(input bit wr, input logic [31:0] a, input logic [31:0] d);
    sb_t it;
    if (wr) begin
      shadow[hw_key(a, 1'b0)] = d[15:0];
      shadow[hw_key(a, 1'b1)] = d[31:16];
      it.is_rd = 1'b0;
    end else begin
      exp_last_rd = {sh(hw_key(a, 1'b1)), sh(hw_key(a, 1'b0))};
      it.is_rd = 1'b1;
    end
    it.exp_rd = exp_last_rd;
    sb_q.push_back(it);
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  // Request is held only for the IDLE sampling cycle, then dropped during LOW.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    set_inputs(wr, rd, a, d);
    push_expect(wr, a, d);
    @(posedge clk); #1;
    set_inputs(1'b0, 1'b0, a, d);
    wait_ready();
  endtask

  initial begin : monitor
    int   lat;
    bit   active;
    bit   we_seen;
    sb_t  it;
    lat = 0; active = 1'b0; we_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat = 0; active = 1'b0; we_seen = 1'b0;
      end else if (!ready) begin
        active = 1'b1;
        lat++;
        if (!SRAM_WE_N) we_seen = 1'b1;
      end else if (active) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          it = sb_q.pop_front();
          check_eq("latency", lat, LAT);
          check_eq("readData", readData, it.exp_rd);
          if (it.is_rd) check_eq("read_we_n_held", {31'd0, we_seen}, 32'd0);
        end
        lat = 0; active = 1'b0; we_seen = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = 16'h0000;
    rst = 1'b1;
    set_inputs(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_readData", readData, 32'd0);
    check_eq("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check_eq("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    check_eq("tie_offs", {28'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store, then load back.
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    check_eq("t1_sram0", {16'd0, mem[0]}, 32'h0000BEEF);
    check_eq("t1_sram1", {16'd0, mem[1]}, 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1024, 32'h0);

    // Back-to-back: wrEn held through DONE, address moved mid-access.
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D);
    push_expect(1'b1, 32'd1024, 32'hCAFEF00D);
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b0, 32'd1028, 32'h12345678);
    push_expect(1'b1, 32'd1028, 32'h12345678);
    wait_ready();
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("b2b_start_after_done", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    set_inputs(1'b0, 1'b0, 32'd1028, 32'h0);
    wait_ready();
    check_eq("t3_sram0", {16'd0, mem[0]}, 32'h0000F00D);
    check_eq("t3_sram2", {16'd0, mem[2]}, 32'h00005678);
    check_eq("t3_sram3", {16'd0, mem[3]}, 32'h00001234);

    // Both enables: write wins, readData keeps DEADBEEF.
    access(1'b1, 1'b1, 32'd1036, 32'hA5A55A5A);
    check_eq("t4_sram6", {16'd0, mem[6]}, 32'h00005A5A);
    check_eq("t4_sram7", {16'd0, mem[7]}, 32'h0000A5A5);

    // Reset during the first HIGH cycle of a store.
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b0, 32'd1028, 32'h9999AAAA);
    shadow[hw_key(32'd1028, 1'b0)] = 16'hAAAA;
    @(posedge clk); #1;
    set_inputs(1'b0, 1'b0, 32'd1028, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_pre_addr", {14'd0, SRAM_ADDR}, 32'd3);
    check_eq("t5_pre_we_n", {31'd0, SRAM_WE_N}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("t5_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check_eq("t5_ready", {31'd0, ready}, 32'd1);
    check_eq("t5_readData", readData, 32'd0);
    check_eq("t5_addr", {14'd0, SRAM_ADDR}, 32'd0);
    sb_q.delete();
    exp_last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("t5_sram2", {16'd0, mem[2]}, 32'h0000AAAA);
    check_eq("t5_sram3", {16'd0, mem[3]}, 32'h00001234);

    // Load with rdEn dropped during LOW.
    access(1'b0, 1'b1, 32'd1028, 32'h0);

    // Address below the base wraps to the top of the SRAM.
    access(1'b1, 1'b0, 32'd1020, 32'h0BADC0DE);
    check_eq("wrap_lo", {16'd0, mem[18'h3FFFE]}, 32'h0000C0DE);
    check_eq("wrap_hi", {16'd0, mem[18'h3FFFF]}, 32'h00000BAD);
    access(1'b0, 1'b1, 32'd1020, 32'h0);

    repeat (4) @(negedge clk);
    check_eq("rd_hold_idle", readData, exp_last_rd);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
